// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - RV32M function codes, FSM states and operand-sign helpers
package muldiv_unit_pkg;

  localparam logic [2:0] FN_MUL    = 3'b000;
  localparam logic [2:0] FN_MULH   = 3'b001;
  localparam logic [2:0] FN_MULHSU = 3'b010;
  localparam logic [2:0] FN_MULHU  = 3'b011;
  localparam logic [2:0] FN_DIV    = 3'b100;
  localparam logic [2:0] FN_DIVU   = 3'b101;
  localparam logic [2:0] FN_REM    = 3'b110;
  localparam logic [2:0] FN_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic is_div(input logic [2:0] fn);
    return fn[2];
  endfunction

  function automatic logic is_rem(input logic [2:0] fn);
    return fn[2] & fn[1];
  endfunction

  function automatic logic is_signed_a(input logic [2:0] fn);
    return (fn != FN_MULHU) && (fn != FN_DIVU) && (fn != FN_REMU);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] fn);
    return is_signed_a(fn) && (fn != FN_MULHSU);
  endfunction

endpackage

// File: rtl/muldiv_unit_iter.sv
// rtl/muldiv_unit_iter.sv - unsigned radix-2 datapath: shift-add multiply / restoring divide
module muldiv_unit_iter #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              en_i,
  input  logic              div_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  output logic [2*XLEN-1:0] prod_o,
  output logic [XLEN-1:0]   quo_o,
  output logic [XLEN-1:0]   rem_o
);

  // The low half of prod_q doubles as the dividend/quotient shift register.
  logic [2*XLEN-1:0] prod_q;
  logic [XLEN-1:0]   rem_q;
  logic [XLEN-1:0]   b_q;
  logic              div_q;

  logic [XLEN:0] mul_sum;
  logic [XLEN:0] div_trial;
  logic [XLEN:0] div_diff;

  always_comb begin
    mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, b_q} : '0);
    div_trial = {rem_q, prod_q[XLEN-1]};
    div_diff  = div_trial - {1'b0, b_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prod_q <= '0;
      rem_q  <= '0;
      b_q    <= '0;
      div_q  <= 1'b0;
    end else if (load_i) begin
      prod_q <= {{XLEN{1'b0}}, a_i};
      rem_q  <= '0;
      b_q    <= b_i;
      div_q  <= div_i;
    end else if (en_i) begin
      if (div_q) begin
        if (!div_diff[XLEN]) begin
          rem_q              <= div_diff[XLEN-1:0];
          prod_q[XLEN-1:0]   <= {prod_q[XLEN-2:0], 1'b1};
        end else begin
          rem_q              <= div_trial[XLEN-1:0];
          prod_q[XLEN-1:0]   <= {prod_q[XLEN-2:0], 1'b0};
        end
      end else begin
        prod_q <= {mul_sum, prod_q[XLEN-1:1]};
      end
    end
  end

  assign prod_o = prod_q;
  assign quo_o  = prod_q[XLEN-1:0];
  assign rem_o  = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit with start/busy/done handshake
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      FUNC,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] S
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       fn_q, fn_d;
  logic             neg_q, neg_d;
  logic [XLEN-1:0]  s_q, s_d;

  logic              load, en;
  logic              sa, sb, div0, ovf;
  logic [XLEN-1:0]   a_mag, b_mag, special_res;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo, rem, div_sel, div_fix, result;

  muldiv_unit_iter #(.XLEN(XLEN)) u_iter (
    .clk    (clk),
    .reset  (reset),
    .load_i (load),
    .en_i   (en),
    .div_i  (is_div(FUNC)),
    .a_i    (a_mag),
    .b_i    (b_mag),
    .prod_o (prod),
    .quo_o  (quo),
    .rem_o  (rem)
  );

  always_comb begin
    sa    = is_signed_a(FUNC) & A[XLEN-1];
    sb    = is_signed_b(FUNC) & B[XLEN-1];
    a_mag = sa ? -A : A;
    b_mag = sb ? -B : B;
    div0  = is_div(FUNC) && (B == '0);
    ovf   = is_div(FUNC) && is_signed_a(FUNC) &&
            (A == {1'b1, {(XLEN-1){1'b0}}}) && (B == '1);
    if (is_rem(FUNC)) special_res = div0 ? A : '0;
    else              special_res = div0 ? '1 : A;
  end

  // Sign correction is applied to the full product so high-half results stay exact.
  always_comb begin
    prod_fix = neg_q ? -prod : prod;
    div_sel  = is_rem(fn_q) ? rem : quo;
    div_fix  = neg_q ? -div_sel : div_sel;
    case (fn_q)
      FN_MUL:                        result = prod_fix[XLEN-1:0];
      FN_MULH, FN_MULHSU, FN_MULHU:  result = prod_fix[2*XLEN-1:XLEN];
      default:                       result = div_fix;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fn_d    = fn_q;
    neg_d   = neg_q;
    s_d     = s_q;
    load    = 1'b0;
    en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          fn_d  = FUNC;
          neg_d = is_rem(FUNC) ? sa : (sa ^ sb);
          if (div0 || ovf) begin
            s_d     = special_res;
            state_d = ST_DONE;
          end else begin
            load    = 1'b1;
            cnt_d   = CNT_W'(XLEN - 1);
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        if (flush) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          en = 1'b1;
          if (cnt_q == '0) state_d = ST_FIX;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      ST_FIX: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          s_d     = result;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      fn_q    <= FN_MUL;
      neg_q   <= 1'b0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fn_q    <= fn_d;
      neg_q   <= neg_d;
      s_q     <= s_d;
    end
  end

  assign busy = (state_q == ST_CALC) || (state_q == ST_FIX);
  assign done = (state_q == ST_DONE);
  assign S    = s_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit at XLEN=32 and XLEN=16
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, flush;
  logic [2:0]  func;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] s;

  logic        start16, flush16;
  logic [2:0]  func16;
  logic [15:0] a16, b16;
  logic        busy16, done16;
  logic [15:0] s16;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] q32[$];
  logic [15:0] q16[$];
  logic [31:0] last_s = '0;

  muldiv_unit #(.XLEN(32)) dut32 (
    .clk(clk), .reset(rst), .start(start), .FUNC(func), .A(a), .B(b),
    .flush(flush), .busy(busy), .done(done), .S(s)
  );

  muldiv_unit #(.XLEN(16)) dut16 (
    .clk(clk), .reset(rst), .start(start16), .FUNC(func16), .A(a16), .B(b16),
    .flush(flush16), .busy(busy16), .done(done16), .S(s16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue32(input logic [2:0] fn, input logic [31:0] aa, input logic [31:0] bb,
                         input bit push, input logic [31:0] ex);
    start = 1'b1; func = fn; a = aa; b = bb;
    tick();
    start = 1'b0; a = $urandom; b = $urandom;
    if (push) q32.push_back(ex);
  endtask

  task automatic wait32(output logic [31:0] res, output int lat, output int bc, output bit ok);
    lat = 1; bc = 0; ok = 1'b0; res = 'x;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        ok = 1'b1; res = s;
        break;
      end
      if (busy) bc++;
      tick();
      lat++;
    end
    if (ok) tick();
  endtask

  task automatic issue16(input logic [2:0] fn, input logic [15:0] aa, input logic [15:0] bb,
                         input logic [15:0] ex);
    start16 = 1'b1; func16 = fn; a16 = aa; b16 = bb;
    tick();
    start16 = 1'b0; a16 = 16'(($urandom)); b16 = 16'(($urandom));
    q16.push_back(ex);
  endtask

  task automatic wait16(output logic [15:0] res, output int lat, output bit ok);
    lat = 1; ok = 1'b0; res = 'x;
    for (int i = 0; i < 100; i++) begin
      if (done16) begin
        ok = 1'b1; res = s16;
        break;
      end
      tick();
      lat++;
    end
    if (ok) tick();
  endtask

  task automatic test_reset();
    n_checks++;
    if ({busy, done, s} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset32 busy=%b done=%b S=%h required 0/0/0", busy, done, s);
    end
    n_checks++;
    if ({busy16, done16, s16} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset16 busy=%b done=%b S=%h required 0/0/0", busy16, done16, s16);
    end
  endtask

  task automatic test_mul_latency();
    logic [31:0] res, ex;
    int lat, bc;
    bit ok;
    issue32(FN_MUL, 32'd7, 32'hFFFFFFFD, 1'b1, 32'hFFFFFFEB);
    wait32(res, lat, bc, ok);
    ex = q32.pop_front();
    n_checks++;
    if (!ok || res !== ex) begin
      n_fail++;
      $display("FAIL mul_result got=%h required=%h ok=%0d", res, ex, ok);
    end
    n_checks++;
    if (lat != 34) begin
      n_fail++;
      $display("FAIL mul_latency got=%0d required=34", lat);
    end
    n_checks++;
    if (bc != 33) begin
      n_fail++;
      $display("FAIL mul_busy_cycles got=%0d required=33", bc);
    end
    last_s = ex;
  endtask

  task automatic test_table(input string name, input logic [2:0] fns[4], input logic [31:0] as[4],
                            input logic [31:0] bs[4], input logic [31:0] exs[4],
                            input int n, input int req_lat);
    logic [31:0] res, ex;
    int lat, bc;
    bit ok;
    for (int i = 0; i < n; i++) begin
      issue32(fns[i], as[i], bs[i], 1'b1, exs[i]);
      wait32(res, lat, bc, ok);
      ex = (q32.size() > 0) ? q32.pop_front() : 32'hx;
      n_checks++;
      if (!ok || res !== ex) begin
        n_fail++;
        $display("FAIL %s[%0d] got=%h required=%h ok=%0d", name, i, res, ex, ok);
      end
      n_checks++;
      if (lat != req_lat) begin
        n_fail++;
        $display("FAIL %s_latency[%0d] got=%0d required=%0d", name, i, lat, req_lat);
      end
      last_s = ex;
    end
  endtask

  task automatic test_high_mul();
    logic [2:0]  f[4] = '{FN_MULH, FN_MULHU, FN_MULHSU, FN_MUL};
    logic [31:0] x[4] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};
    logic [31:0] y[4] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};
    logic [31:0] e[4] = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0};
    test_table("high_mul", f, x, y, e, 3, 34);
  endtask

  task automatic test_div_rem();
    logic [2:0]  f[4] = '{FN_DIV, FN_REM, FN_DIVU, FN_REMU};
    logic [31:0] x[4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9};
    logic [31:0] y[4] = '{32'd2, 32'd2, 32'd2, 32'd2};
    logic [31:0] e[4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFC, 32'h1};
    test_table("div_rem", f, x, y, e, 4, 34);
  endtask

  task automatic test_special();
    logic [2:0]  f[4] = '{FN_DIV, FN_REMU, FN_DIV, FN_REM};
    logic [31:0] x[4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
    logic [31:0] y[4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] e[4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0};
    test_table("special", f, x, y, e, 4, 1);
  endtask

  task automatic test_start_ignored();
    logic [31:0] res, ex;
    int lat, bc, extra;
    bit ok;
    issue32(FN_MUL, 32'd3, 32'd5, 1'b1, 32'd15);
    repeat (5) tick();
    start = 1'b1; func = FN_DIVU; a = 32'd100; b = 32'd7;
    tick();
    start = 1'b0;
    wait32(res, lat, bc, ok);
    ex = q32.pop_front();
    n_checks++;
    if (!ok || res !== ex) begin
      n_fail++;
      $display("FAIL start_ignored_result got=%h required=%h ok=%0d", res, ex, ok);
    end
    n_checks++;
    if (lat != 28) begin
      n_fail++;
      $display("FAIL start_ignored_latency got=%0d required=28", lat);
    end
    last_s = ex;
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) extra++;
      tick();
    end
    n_checks++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL start_ignored_no_second_op got=%0d active cycles required=0", extra);
    end
  endtask

  task automatic test_flush();
    int dones;
    issue32(FN_DIVU, 32'd1000, 32'd3, 1'b0, 32'd0);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || s !== last_s) begin
      n_fail++;
      $display("FAIL flush_calc busy=%b done=%b S=%h required 0/0/%h", busy, done, s, last_s);
    end
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dones++;
      tick();
    end
    n_checks++;
    if (dones != 0) begin
      n_fail++;
      $display("FAIL flush_no_done got=%0d required=0", dones);
    end
    start = 1'b1; flush = 1'b1; func = FN_MUL; a = 32'd2; b = 32'd2;
    tick();
    start = 1'b0; flush = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle busy=%b done=%b required 0/0", busy, done);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    issue32(FN_MULHU, 32'd9, 32'd9, 1'b0, 32'd0);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || s !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid busy=%b done=%b S=%h required 0/0/0", busy, done, s);
    end
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dones++;
      tick();
    end
    n_checks++;
    if (dones != 0) begin
      n_fail++;
      $display("FAIL reset_mid_no_done got=%0d required=0", dones);
    end
  endtask

  task automatic test_xlen16();
    logic [15:0] res, ex;
    int lat;
    bit ok;
    issue16(FN_MULHU, 16'hFFFF, 16'hFFFF, 16'hFFFE);
    wait16(res, lat, ok);
    ex = q16.pop_front();
    n_checks++;
    if (!ok || res !== ex) begin
      n_fail++;
      $display("FAIL x16_mulhu got=%h required=%h ok=%0d", res, ex, ok);
    end
    n_checks++;
    if (lat != 18) begin
      n_fail++;
      $display("FAIL x16_latency got=%0d required=18", lat);
    end
    issue16(FN_DIVU, 16'hFFFF, 16'h0010, 16'h0FFF);
    wait16(res, lat, ok);
    ex = q16.pop_front();
    n_checks++;
    if (!ok || res !== ex) begin
      n_fail++;
      $display("FAIL x16_divu got=%h required=%h ok=%0d", res, ex, ok);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; func = FN_MUL; a = '0; b = '0;
    start16 = 1'b0; flush16 = 1'b0; func16 = FN_MUL; a16 = '0; b16 = '0;
    repeat (3) tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_mul_latency();
    test_high_mul();
    test_div_rem();
    test_special();
    test_start_ignored();
    test_flush();
    test_reset_mid();
    test_xlen16();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
